// File: rtl/clock_meter_pkg.sv
// clock_meter_pkg
//  Shared types and helpers for the clock measurement / clock divider slice.
//  - meas_state_t : measurement FSM state encoding
//  - CeilLog2     : ceiling of log2, used to size counters from frequencies
package clock_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meas_state_t;

  // Smallest r such that 2**r >= value (0 for value <= 1).
  function automatic int CeilLog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect
//  Brings an asynchronous level into the clk_FPGA domain and produces
//  single-cycle rise/fall pulses.
//  Ports:
//   clk_FPGA  in  reference clock
//   reset     in  asynchronous, active-low reset
//   async_in  in  asynchronous input level
//   level     out synchronized level, aligned with the rise/fall pulses
//   rise      out one-cycle pulse per 0->1 transition of async_in
//   fall      out one-cycle pulse per 1->0 transition of async_in
//  A transition on async_in shows up on rise/fall SYNC_STAGES+1 cycles later.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_FPGA,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   rise_r;
  logic                   fall_r;

  // Synchronizer chain, previous-level register and registered edge compare.
  always_ff @(posedge clk_FPGA or negedge reset) begin
    if (!reset) begin
      sync_r <= '0;
      prev_r <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
      prev_r <= sync_r[SYNC_STAGES-1];
      rise_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
      fall_r <= ~sync_r[SYNC_STAGES-1] & prev_r;
    end
  end

  // prev_r updates on the same edge as the pulses, so it is the level they describe.
  assign level = prev_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/clock_period_meter.sv
// clock_period_meter
//  Measures the period and high time of a slow clock / square wave in
//  clk_FPGA cycles and flags loss of that clock.
//  Ports:
//   clk_FPGA      in  reference clock (REFERENCE_CLOCK Hz)
//   reset         in  asynchronous, active-low reset
//   enable        in  1 = measure, 0 = idle
//   clock_in      in  measured signal, asynchronous to clk_FPGA
//   period        out cycles between consecutive rising edges of clock_in
//   high_time     out cycles clock_in was high within that period
//   period_valid  out one-cycle pulse when period/high_time update
//   no_clock      out no rising edge seen within 2**NBITS_PERIOD-1 cycles
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int REFERENCE_CLOCK = 50_000_000,
  parameter int NBITS_PERIOD    = 24,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                    clk_FPGA,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    clock_in,
  output logic [NBITS_PERIOD-1:0] period,
  output logic [NBITS_PERIOD-1:0] high_time,
  output logic                    period_valid,
  output logic                    no_clock
);

  localparam logic [NBITS_PERIOD-1:0] CNT_MAX = {NBITS_PERIOD{1'b1}};
  localparam logic [NBITS_PERIOD-1:0] CNT_ONE = {{(NBITS_PERIOD-1){1'b0}}, 1'b1};

  meas_state_t             state_r;
  meas_state_t             state_next_s;
  logic [NBITS_PERIOD-1:0] counter_r;
  logic [NBITS_PERIOD-1:0] high_shadow_r;
  logic [NBITS_PERIOD-1:0] period_r;
  logic [NBITS_PERIOD-1:0] high_time_r;
  logic                    period_valid_r;
  logic                    no_clock_r;

  logic level_s;
  logic rise_raw_s;
  logic fall_raw_s;
  logic rise_s;
  logic fall_s;
  logic at_max_s;

  logic start_s;
  logic publish_s;
  logic timeout_s;
  logic capture_s;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk_FPGA (clk_FPGA),
    .reset    (reset),
    .async_in (clock_in),
    .level    (level_s),
    .rise     (rise_raw_s),
    .fall     (fall_raw_s)
  );

  // Pulses are only trusted when the aligned level agrees with their direction.
  assign rise_s   = rise_raw_s & level_s;
  assign fall_s   = fall_raw_s & ~level_s;
  assign at_max_s = (counter_r == CNT_MAX);

  // FSM state register.
  always_ff @(posedge clk_FPGA or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; dropping enable always returns to IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) state_next_s = ARM;
        else        state_next_s = IDLE;
      end
      ARM: begin
        if (!enable)     state_next_s = IDLE;
        else if (rise_s) state_next_s = MEASURE;
        else             state_next_s = ARM;
      end
      MEASURE: begin
        // A rise on the max-count cycle wins over the timeout.
        if (!enable)        state_next_s = IDLE;
        else if (rise_s)    state_next_s = MEASURE;
        else if (at_max_s)  state_next_s = ARM;
        else                state_next_s = MEASURE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM output decode: datapath strobes for the current state and edges.
  always_comb begin
    start_s   = 1'b0;
    publish_s = 1'b0;
    timeout_s = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        start_s = 1'b0;
      end
      ARM: begin
        if (enable) start_s = rise_s;
        else        start_s = 1'b0;
      end
      MEASURE: begin
        if (enable) begin
          publish_s = rise_s;
          timeout_s = ~rise_s & at_max_s;
          capture_s = fall_s;
        end else begin
          publish_s = 1'b0;
        end
      end
      default: start_s = 1'b0;
    endcase
  end

  // Cycle counter: 1 on the cycle after an accepted rise, 0 when not measuring.
  always_ff @(posedge clk_FPGA or negedge reset) begin
    if (!reset) begin
      counter_r <= '0;
    end else if (!enable) begin
      counter_r <= '0;
    end else if (start_s || publish_s) begin
      counter_r <= CNT_ONE;
    end else if (timeout_s) begin
      counter_r <= '0;
    end else if (state_r == MEASURE) begin
      counter_r <= counter_r + CNT_ONE;
    end else begin
      counter_r <= '0;
    end
  end

  // High-time shadow, captured on the falling edge inside a period.
  always_ff @(posedge clk_FPGA or negedge reset) begin
    if (!reset) begin
      high_shadow_r <= '0;
    end else if (capture_s) begin
      high_shadow_r <= counter_r;
    end else begin
      high_shadow_r <= high_shadow_r;
    end
  end

  // Result registers; only a completed period is ever published.
  always_ff @(posedge clk_FPGA or negedge reset) begin
    if (!reset) begin
      period_r       <= '0;
      high_time_r    <= '0;
      period_valid_r <= 1'b0;
    end else begin
      period_valid_r <= publish_s;
      if (publish_s) begin
        period_r    <= counter_r;
        high_time_r <= high_shadow_r;
      end else begin
        period_r    <= period_r;
        high_time_r <= high_time_r;
      end
    end
  end

  // Loss-of-clock flag: set on timeout, cleared by a result or by disabling.
  always_ff @(posedge clk_FPGA or negedge reset) begin
    if (!reset) begin
      no_clock_r <= 1'b0;
    end else if (!enable || publish_s) begin
      no_clock_r <= 1'b0;
    end else if (timeout_s) begin
      no_clock_r <= 1'b1;
    end else begin
      no_clock_r <= no_clock_r;
    end
  end

  assign period       = period_r;
  assign high_time    = high_time_r;
  assign period_valid = period_valid_r;
  assign no_clock     = no_clock_r;

endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter
//  Drives clock_in as a sequence of high/low phases (fixed and random) and
//  compares every period_valid pulse against a queue of expected
//  (period, high_time) pairs derived from the phase lengths. Also covers
//  reset values, timeout timing, reset mid-period and enable drop.
module tb_clock_period_meter;

  localparam int NB = 8;

  logic          clk_FPGA;
  logic          reset;
  logic          enable;
  logic          clock_in;
  logic [NB-1:0] period;
  logic [NB-1:0] high_time;
  logic          period_valid;
  logic          no_clock;

  int tests_run;
  int tests_failed;
  int cyc;
  int last_valid_cyc;
  int nc_rise_cyc;
  logic prev_nc;

  // Reference model state: expected results and the previous input cycle.
  int exp_period[$];
  int exp_high[$];
  bit have_rise;
  int prev_h;
  int prev_l;

  clock_period_meter #(
    .REFERENCE_CLOCK (50_000_000),
    .NBITS_PERIOD    (NB),
    .SYNC_STAGES     (2)
  ) dut (
    .clk_FPGA     (clk_FPGA),
    .reset        (reset),
    .enable       (enable),
    .clock_in     (clock_in),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .no_clock     (no_clock)
  );

  initial clk_FPGA = 1'b0;
  always #10 clk_FPGA = ~clk_FPGA;

  always @(posedge clk_FPGA) cyc <= cyc + 1;

  task automatic check_value(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_FPGA);
      #1;
    end
  endtask

  // One input cycle = rise, h cycles high, fall, l cycles low. Every rise
  // after the first one of an enabled run completes the previous cycle.
  task automatic run_wave(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      if (enable) begin
        if (have_rise) begin
          exp_period.push_back(prev_h + prev_l);
          exp_high.push_back(prev_h);
        end
        have_rise = 1'b1;
      end else begin
        have_rise = 1'b0;
      end
      prev_h = h;
      prev_l = l;
      clock_in = 1'b1;
      step(h);
      clock_in = 1'b0;
      step(l);
    end
  endtask

  // Monitor: every result pulse must match the oldest expected result.
  always @(negedge clk_FPGA) begin
    if (period_valid === 1'b1) begin
      last_valid_cyc = cyc;
      check_value("no_clock_at_valid", int'(no_clock), 0);
      if (exp_period.size() == 0) begin
        check_value("unexpected_valid", int'(period_valid), 0);
      end else begin
        check_value("period", int'(period), exp_period.pop_front());
        check_value("high_time", int'(high_time), exp_high.pop_front());
      end
    end
    if (no_clock === 1'b1 && prev_nc === 1'b0) nc_rise_cyc = cyc;
    prev_nc = no_clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests_run = 0;
    tests_failed = 0;
    cyc = 0;
    last_valid_cyc = -1;
    nc_rise_cyc = -1;
    prev_nc = 1'b0;
    have_rise = 1'b0;
    prev_h = 0;
    prev_l = 0;
    reset = 1'b0;
    enable = 1'b0;
    clock_in = 1'b0;

    // Reset values.
    step(3);
    check_value("rst_period", int'(period), 0);
    check_value("rst_high_time", int'(high_time), 0);
    check_value("rst_valid", int'(period_valid), 0);
    check_value("rst_no_clock", int'(no_clock), 0);
    reset = 1'b1;
    step(2);
    enable = 1'b1;
    step(2);

    // 4-cycle input (2 high / 2 low).
    run_wave(2, 2, 8);
    // 3/5 then 6/2.
    run_wave(3, 5, 4);
    run_wave(6, 2, 4);
    // Randomized duty cycles.
    for (int i = 0; i < 40; i++) begin
      run_wave($urandom_range(1, 12), $urandom_range(1, 12), 1);
    end
    // Toggling every cycle for 1000 cycles.
    run_wave(1, 1, 500);

    // Timeout: lock on 4-cycle clock, then one last rise and stuck low.
    run_wave(2, 2, 5);
    nc_rise_cyc = -1;
    run_wave(2, 300, 1);
    have_rise = 1'b0;
    check_value("timeout_delay", nc_rise_cyc - last_valid_cyc, 255);
    check_value("no_clock_set", int'(no_clock), 1);
    // The first rise after re-arming only restarts.
    run_wave(2, 2, 1);
    check_value("no_clock_held", int'(no_clock), 1);
    run_wave(2, 2, 6);
    check_value("no_clock_cleared", int'(no_clock), 0);

    // Reset in the middle of a high phase.
    run_wave(2, 2, 3);
    clock_in = 1'b1;
    step(1);
    reset = 1'b0;
    #1;
    check_value("midrst_period", int'(period), 0);
    check_value("midrst_high_time", int'(high_time), 0);
    check_value("midrst_valid", int'(period_valid), 0);
    check_value("midrst_no_clock", int'(no_clock), 0);
    exp_period.delete();
    exp_high.delete();
    have_rise = 1'b0;
    clock_in = 1'b0;
    step(3);
    reset = 1'b1;
    step(2);
    run_wave(2, 2, 6);

    // Enable dropped for 10 cycles while the input keeps toggling.
    step(6);
    enable = 1'b0;
    have_rise = 1'b0;
    run_wave(2, 2, 2);
    step(2);
    check_value("dis_period", int'(period), 4);
    check_value("dis_high_time", int'(high_time), 2);
    check_value("dis_no_clock", int'(no_clock), 0);
    enable = 1'b1;
    run_wave(2, 2, 6);

    // Drain and confirm every expected result was published.
    step(12);
    check_value("pending_results", exp_period.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
